imem_loader: RTL and testbench

//  Write-side partner of the fetch path: streams a program into the 64x16 instruction memory

---
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: streams bytes into the 64x16 instruction memory and freezes the CPU while loading.
// Define IMEM_LOADER_CKSUM_EN to check a trailing XOR checksum byte after the last word.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int WORDS  = 64
) (
  input  logic              CLOCK,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [ADDR_W:0]   in_len,
  input  logic [7:0]        in_byte,
  input  logic              in_byte_vld,
  output logic              out_byte_rdy,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data,
  output logic              out_cpu_hold,
  output logic              out_done,
  output logic              out_err
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4,
    CKSUM   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;
`endif

  state_t            state;
  state_t            next_state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              err;
  logic              len_ok;
  logic              last_word;
  logic              xfer;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  assign len_ok    = (in_len != '0) && (in_len <= LEN_MAX);
  assign last_word = ({1'b0, addr} + LEN_ONE) == len;
  assign xfer      = out_byte_rdy && in_byte_vld;

  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake and strobes decode the state register only, so rdy never depends on vld.
  always_comb begin
    next_state   = state;
    out_byte_rdy = 1'b0;
    out_wr_en    = 1'b0;
    out_cpu_hold = 1'b0;
    out_done     = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) begin
          next_state = len_ok ? LOAD_HI : DONE;
        end
      end
      LOAD_HI: begin
        out_byte_rdy = 1'b1;
        out_cpu_hold = 1'b1;
        if (in_byte_vld) begin
          next_state = LOAD_LO;
        end
      end
      LOAD_LO: begin
        out_byte_rdy = 1'b1;
        out_cpu_hold = 1'b1;
        if (in_byte_vld) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        out_wr_en    = 1'b1;
        out_cpu_hold = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          next_state = CKSUM;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = LOAD_HI;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM: begin
        out_byte_rdy = 1'b1;
        out_cpu_hold = 1'b1;
        if (in_byte_vld) begin
          next_state = DONE;
        end
      end
`endif
      DONE: begin
        out_done   = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Write address/data are loaded when the low byte lands, so they hold between words.
  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      len     <= '0;
      addr    <= '0;
      hi_byte <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            if (len_ok) begin
              len  <= in_len;
              addr <= '0;
              err  <= 1'b0;
            end else begin
              err  <= 1'b1;
            end
          end
        end
        LOAD_HI: begin
          if (xfer) begin
            hi_byte <= in_byte;
          end
        end
        LOAD_LO: begin
          if (xfer) begin
            wr_addr <= addr;
            wr_data <= DATA_W'({hi_byte, in_byte});
          end
        end
        WRITE: begin
          if (!last_word) begin
            addr <= addr + 1'b1;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM: begin
          if (xfer && (in_byte != cksum)) begin
            err <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  // Running XOR over program bytes only; the checksum byte itself is excluded.
  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      cksum <= '0;
    end else if (state == IDLE && in_start && len_ok) begin
      cksum <= '0;
    end else if (xfer && (state == LOAD_HI || state == LOAD_LO)) begin
      cksum <= cksum ^ in_byte;
    end
  end
`endif

  assign out_wr_addr = wr_addr;
  assign out_wr_data = wr_data;
  assign out_err     = err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: directed scoreboard bench for imem_loader (write order, timing, errors, reset).
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int WORDS  = 64;

  typedef struct {
    logic [ADDR_W+DATA_W-1:0] w;
    int                       c;
  } obs_t;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic [ADDR_W:0]   len     = '0;
  logic [7:0]        byte_in = '0;
  logic              vld     = 1'b0;
  logic              rdy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              hold;
  logic              done;
  logic              err;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) dut (
    .CLOCK        (clk),
    .in_rst       (rst_n),
    .in_start     (start),
    .in_len       (len),
    .in_byte      (byte_in),
    .in_byte_vld  (vld),
    .out_byte_rdy (rdy),
    .out_wr_en    (wr_en),
    .out_wr_addr  (wr_addr),
    .out_wr_data  (wr_data),
    .out_cpu_hold (hold),
    .out_done     (done),
    .out_err      (err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int hold_cnt   = 0;
  int start_cyc  = 0;
  int done_cyc   = 0;
  bit hold_drop  = 1'b0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  obs_t                     obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every write strobe with the cycle it was seen in.
  always @(negedge clk) begin
    obs_t o;
    if (wr_en) begin
      o.w = {wr_addr, wr_data};
      o.c = cyc;
      obs_q.push_back(o);
    end
    if (hold) hold_cnt = hold_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic timeout(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic do_start(input logic [ADDR_W:0] l);
    start     = 1'b1;
    len       = l;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok  = 1'b0;
    vld = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (!hold) hold_drop = 1'b1;
    end
    byte_in = b;
    vld     = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (!hold) hold_drop = 1'b1;
      if (rdy) begin
        @(posedge clk);
        #1 vld = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("byte_handshake");
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < max_cyc; t++) begin
      if (done) begin
        ok       = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("done_pulse");
  endtask

  // Pop every observed write against the expected queue, then require both empty.
  task automatic drain(input string tag);
    obs_t o;
    logic [ADDR_W+DATA_W-1:0] e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $error("FAIL %s_unexpected: observed %0h expected none", tag, o.w);
      end else begin
        e = exp_q.pop_front();
        assert (o.w === e) else begin
          mismatched++;
          $error("FAIL %s_word: observed %0h expected %0h", tag, o.w, e);
        end
      end
    end
    check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : stim
    obs_t o;
    int   h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {25'd0, rdy, wr_en, hold, done, err, 2'b00},
          32'd0);
    check("rst_addr_data", {10'd0, wr_addr, wr_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: len=2, back-to-back bytes
    exp_q.push_back({6'd0, 16'h1234});
    exp_q.push_back({6'd1, 16'hABCD});
    do_start(7'd2);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    wait_done(20);
    check("t1_done_cyc", 32'(done_cyc - start_cyc), 32'd7);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_hold_in_done", {31'd0, hold}, 32'd0);
    check("t1_nwrites", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("t1_wr0_cyc", 32'(obs_q[0].c - start_cyc), 32'd3);
      check("t1_wr1_cyc", 32'(obs_q[1].c - start_cyc), 32'd6);
    end
    drain("t1");
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, done}, 32'd0);
    check("t1_hold_data", {10'd0, wr_addr, wr_data}, {10'd0, 6'd1, 16'hABCD});

    // Test 2: len=1 with 4-cycle valid gaps; hold must stay up until done
    exp_q.push_back({6'd0, 16'h5A3C});
    hold_drop = 1'b0;
    do_start(7'd1);
    send_byte(8'h5A, 4);
    send_byte(8'h3C, 4);
    wait_done(20);
    check("t2_hold_continuous", {31'd0, hold_drop}, 32'd0);
    check("t2_err", {31'd0, err}, 32'd0);
    drain("t2");
    @(negedge clk);

    // Test 3: illegal lengths 0 and 65
    for (int k = 0; k < 2; k++) begin
      h0 = hold_cnt;
      do_start((k == 0) ? 7'd0 : 7'd65);
      wait_done(5);
      check("t3_done_next_cyc", 32'(done_cyc - start_cyc), 32'd1);
      check("t3_err", {31'd0, err}, 32'd1);
      @(negedge clk);
      check("t3_no_writes", 32'(obs_q.size()), 32'd0);
      check("t3_no_hold", 32'(hold_cnt - h0), 32'd0);
      drain("t3");
    end

    // Test 5: async reset while in LOAD_LO, then a clean reload
    do_start(7'd2);
    send_byte(8'h77, 0);
    check("t5_in_load_lo", {30'd0, rdy, hold}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_outputs", {25'd0, rdy, wr_en, hold, done, err, 2'b00}, 32'd0);
    check("t5_async_addr_data", {10'd0, wr_addr, wr_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({6'd0, 16'hC3E1});
    do_start(7'd1);
    send_byte(8'hC3, 0);
    send_byte(8'hE1, 0);
    wait_done(20);
    check("t5_err", {31'd0, err}, 32'd0);
    drain("t5");
    @(negedge clk);

    // Test 4: full 64-word load, data equal to address
    for (int k = 0; k < WORDS; k++) exp_q.push_back({6'(k), 16'(k)});
    do_start(7'd64);
    for (int k = 0; k < WORDS; k++) begin
      send_byte(8'h00, 0);
      send_byte(8'(k), 0);
    end
    wait_done(20);
    check("t4_nwrites", 32'(obs_q.size()), 32'd64);
    if (obs_q.size() > 0) begin
      o = obs_q[obs_q.size()-1];
      check("t4_last_write", 32'(o.w), {10'd0, 6'd63, 16'h003F});
    end
    check("t4_err", {31'd0, err}, 32'd0);
    drain("t4");
    @(negedge clk);

`ifdef IMEM_LOADER_CKSUM_EN
    // Checksum byte: 12^34 = 26 is good, 27 is bad
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({6'd0, 16'h1234});
      do_start(7'd1);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte((k == 0) ? 8'h26 : 8'h27, 0);
      wait_done(20);
      check("t6_err", {31'd0, err}, (k == 0) ? 32'd0 : 32'd1);
      drain("t6");
      @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
